// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and constants for the 12-bit processor fetch path.
//               Holds the sequencer state encoding, the opcodes that steer
//               control flow and the default instruction address width.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    // Sequencer state encoding. The width is fixed at two bits.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Opcodes whose decode produces jump_en / branch for the sequencer.
    localparam logic [2:0] OP_JUMP = 3'd6;
    localparam logic [2:0] OP_BEQ  = 3'd3;

    // Default instruction address width (256-entry instruction memory).
    localparam int IA_WIDTH_DEFAULT = 8;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Combinational next-PC priority mux for the RUN state.
//               Priority: stall > halt > jump > taken branch > pc+1.
// Ports       : pc_i             current program counter
//               stall_i          hold pc, ignore every other control
//               halt_i           current instruction is halt
//               jump_en_i        unconditional jump, target destination_i
//               destination_i    jump target
//               branch_i         current instruction is BEQ
//               branch_taken_i   BEQ condition true
//               branch_target_i  BEQ target
//               next_pc_o        address for the next cycle
//               halt_req_o       request transition to HALTED
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import proc_pkg::*;
#(
    parameter int IA_WIDTH = IA_WIDTH_DEFAULT
) (
    input  logic [IA_WIDTH-1:0] pc_i,
    input  logic                stall_i,
    input  logic                halt_i,
    input  logic                jump_en_i,
    input  logic [IA_WIDTH-1:0] destination_i,
    input  logic                branch_i,
    input  logic                branch_taken_i,
    input  logic [IA_WIDTH-1:0] branch_target_i,
    output logic [IA_WIDTH-1:0] next_pc_o,
    output logic                halt_req_o
);

    // destination_i and branch_target_i are only ever selected behind their
    // own enables, so an unknown target with its enable low cannot reach pc.
    always_comb begin
        next_pc_o  = pc_i;
        halt_req_o = 1'b0;
        if (stall_i) begin
            next_pc_o = pc_i;
        end else if (halt_i) begin
            // pc stays on the halt instruction
            halt_req_o = 1'b1;
        end else if (jump_en_i) begin
            next_pc_o = destination_i;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = branch_target_i;
        end else begin
            // Natural modulo-2^IA_WIDTH wrap
            next_pc_o = pc_i + IA_WIDTH'(1);
        end
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Registered program counter, run/halt control and saturating
//               RUN-cycle counter for the 12-bit processor.
// Ports       : clk, reset (sync, active high)
//               start_i          begin execution from IDLE or HALTED
//               stall_i, halt_i, jump_en_i, destination_i,
//               branch_i, branch_taken_i, branch_target_i  per-instruction
//               control for the instruction currently at pc_o
//               pc_o             address of instruction being executed
//               fetch_valid_o    pc_o is live (state RUN)
//               done_o           program halted
//               cycle_count_o    RUN cycles since last start (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int                 IA_WIDTH   = IA_WIDTH_DEFAULT,
    parameter logic [IA_WIDTH-1:0] START_ADDR = '0,
    parameter int                 CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 jump_en_i,
    input  logic [IA_WIDTH-1:0]  destination_i,
    input  logic                 branch_i,
    input  logic                 branch_taken_i,
    input  logic [IA_WIDTH-1:0]  branch_target_i,
    output logic [IA_WIDTH-1:0]  pc_o,
    output logic                 fetch_valid_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [IA_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [IA_WIDTH-1:0]  sel_pc;
    logic                 sel_halt;

    next_pc_sel #(
        .IA_WIDTH (IA_WIDTH)
    ) u_next_pc_sel (
        .pc_i            (pc_q),
        .stall_i         (stall_i),
        .halt_i          (halt_i),
        .jump_en_i       (jump_en_i),
        .destination_i   (destination_i),
        .branch_i        (branch_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .next_pc_o       (sel_pc),
        .halt_req_o      (sel_halt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start_i) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                // Stall and halt cycles still count as RUN cycles
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                pc_d = sel_pc;
                if (sel_halt) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        fetch_valid_o = (state_q == RUN);
        pc_o          = pc_q;
        done_o        = done_q;
        cycle_count_o = cnt_q;
    end

endmodule : pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter and fetch sequencer for the 12-bit processor.
- Consumes the jump decision (jump_en_i / destination_i) and the BEQ target/condition for the instruction currently at pc_o, and produces the next instruction address.
- Also owns the run/halt control (start, stall, halt) and a cycle counter used for program timing.
- Sits between the instruction memory address port and the decode/jump logic.

Parameters:
- IA_WIDTH, 8, instruction address width
- START_ADDR, 0, address loaded on start
- CNT_WIDTH, 16, cycle counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start_i  in  1  begin execution; honoured only in IDLE or HALTED
- stall_i  in  1  hold pc_o this cycle; instruction not retired
- halt_i  in  1  current instruction is halt
- jump_en_i  in  1  unconditional jump for current instruction
- destination_i  in  IA_WIDTH  jump target
- branch_i  in  1  current instruction is BEQ
- branch_taken_i  in  1  BEQ condition true (ALU equal)
- branch_target_i  in  IA_WIDTH  BEQ target
- pc_o  out  IA_WIDTH  address of instruction being executed
- fetch_valid_o  out  1  pc_o is a live instruction (state RUN)
- done_o  out  1  program halted
- cycle_count_o  out  CNT_WIDTH  RUN cycles since last start

Behaviour:
- Reset (sync, high) overrides everything, including mid-run. Next cycle: state=IDLE, pc_o=0, fetch_valid_o=0, done_o=0, cycle_count_o=0.
- States: IDLE, RUN, HALTED.
- IDLE:
  - Outputs as reset.
  - start_i=1 -> RUN; pc_o<=START_ADDR; cycle_count_o<=0.
- RUN:
  - fetch_valid_o=1 (combinational from state).
  - Every RUN cycle, cycle_count_o increments, stall cycles included. Saturates at all-ones, no wrap.
  - Next-PC priority, evaluated once per cycle:
    1. stall_i=1 -> pc_o held; halt/jump/branch inputs ignored this cycle.
    2. halt_i=1 -> HALTED; pc_o held (points at halt instruction).
    3. jump_en_i=1 -> pc_o<=destination_i.
    4. branch_i=1 and branch_taken_i=1 -> pc_o<=branch_target_i.
    5. Otherwise pc_o<=pc_o+1, modulo 2^IA_WIDTH (max wraps to 0).
  - branch_i=1 with branch_taken_i=0 -> sequential, pc_o+1.
  - jump_en_i and branch both asserted -> jump wins.
  - start_i is ignored in RUN.
- HALTED:
  - done_o=1; fetch_valid_o=0; pc_o and cycle_count_o frozen.
  - start_i=1 -> RUN; pc_o<=START_ADDR; cycle_count_o<=0; done_o falls the same edge.
- Latency:
  - All outputs registered except fetch_valid_o.
  - Redirect takes effect on pc_o one cycle after the decision cycle; no bubble and no delay slot.
- Inputs other than clk, reset and start_i are don't-care outside RUN. An X on destination_i while jump_en_i=0 must not propagate to pc_o.

Decomposition:
- Shared package proc_pkg holds:
  - state enum {IDLE, RUN, HALTED}
  - opcode constants OP_JUMP=3'd6, OP_BEQ=3'd3
  - IA_WIDTH default
- One natural sub-module: next_pc_sel. Purely combinational priority mux that outputs next pc and halt_req.
- The FSM, pc register and counter stay in pc_sequencer.

Test Plan:
- Reset, then start_i pulse, then no redirects for 4 cycles -> pc_o 0,1,2,3,4; fetch_valid_o=1; cycle_count_o=4.
- At pc=5: jump_en_i=1, destination_i=2 with branch_i=1, branch_taken_i=1, branch_target_i=14 in the same cycle -> next pc_o=2 (jump wins). Then at that pc, branch taken alone, target 14 -> next pc_o=14.
- stall_i=1 for 3 cycles with jump_en_i=1 held -> pc_o constant, cycle_count_o +3. Release stall -> next pc_o=destination_i.
- pc_o=255, no redirect -> next pc_o=0. Counter preloaded near max -> cycle_count_o saturates at 65535.
- halt_i at pc=9 -> done_o=1, pc_o stays 9, counter frozen. Then start_i -> pc_o=0, count=0, done_o=0 the next cycle.
- Reset asserted mid-RUN together with jump_en_i -> next cycle IDLE, pc_o=0, all outputs at reset values. start_i asserted in the reset cycle is ignored.
